// File: rtl/align_pkg.sv
// Shared alignment constants: edit-op codes, direction-word encodings and the
// traceback FSM state encoding. The PE direction logic uses the same values.
package align_pkg;

  localparam int DIR_W    = 5;
  localparam int DIAG_BIT = 4;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_M    = 2'b01;
  localparam logic [1:0] OP_I    = 2'b10;
  localparam logic [1:0] OP_D    = 2'b11;

  localparam logic [DIR_W-1:0] DIR_F     = 5'b00011;
  localparam logic [DIR_W-1:0] DIR_F_HAT = 5'b01011;
  localparam logic [DIR_W-1:0] DIR_E     = 5'b00111;
  localparam logic [DIR_W-1:0] DIR_E_HAT = 5'b01111;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_EMIT  = 3'd3,
    ST_FLUSH = 3'd4,
    ST_DONE  = 3'd5
  } tb_state_e;

endpackage

// File: rtl/traceback_unit_dir_decode.sv
// Direction-word decoder: maps one stored direction word to the edit op it
// implies, the coordinate steps it takes, and whether the word is illegal.
module dir_decode
  import align_pkg::*;
#(
  parameter int DIRECTION_WIDTH = DIR_W
) (
  input  logic [DIRECTION_WIDTH-1:0] word,
  output logic [1:0]                 op_code,
  output logic                       dx,
  output logic                       dy,
  output logic                       illegal
);

  // Diagonal bit wins; otherwise only the four gap encodings are legal.
  always_comb begin
    op_code = OP_NONE;
    dx      = 1'b0;
    dy      = 1'b0;
    illegal = 1'b0;
    if (word[DIAG_BIT]) begin
      op_code = OP_M;
      dx      = 1'b1;
      dy      = 1'b1;
    end else if (word == DIRECTION_WIDTH'(DIR_F) || word == DIRECTION_WIDTH'(DIR_F_HAT)) begin
      op_code = OP_I;
      dx      = 1'b1;
    end else if (word == DIRECTION_WIDTH'(DIR_E) || word == DIRECTION_WIDTH'(DIR_E_HAT)) begin
      op_code = OP_D;
      dy      = 1'b1;
    end else begin
      illegal = 1'b1;
    end
  end

endmodule

// File: rtl/traceback_unit.sv
// Traceback unit: walks the direction memory from a start cell back toward the
// origin and streams M/I/D edit ops over a valid/ready handshake. Coordinates
// are held 1-based so that zero means "past the matrix boundary".
module traceback_unit
  import align_pkg::*;
#(
  parameter int ADDRESS_WIDTH   = 8,
  parameter int DIRECTION_WIDTH = DIR_W,
  parameter int RD_LATENCY      = 1
) (
  input  logic                       clk,
  input  logic                       reset_i,
  input  logic                       start_i,
  input  logic [ADDRESS_WIDTH-1:0]   start_x_i,
  input  logic [ADDRESS_WIDTH-1:0]   start_y_i,
  input  logic                       local_mode_i,
  output logic                       rd_en_o,
  output logic [2*ADDRESS_WIDTH-1:0] rd_addr_o,
  input  logic [DIRECTION_WIDTH-1:0] rd_data_i,
  output logic                       op_valid_o,
  output logic [1:0]                 op_code_o,
  input  logic                       op_ready_i,
  output logic [ADDRESS_WIDTH+1:0]   op_count_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       error_o
);

  localparam int CW = ADDRESS_WIDTH + 1;
  localparam int NW = ADDRESS_WIDTH + 2;
  localparam int LW = 2;

  tb_state_e      state_q, state_d;
  logic [CW-1:0]  xi_q, xi_d;
  logic [CW-1:0]  yi_q, yi_d;
  logic           local_q, local_d;
  logic [LW-1:0]  wcnt_q, wcnt_d;
  logic [1:0]     code_q, code_d;
  logic           dx_q, dx_d;
  logic           dy_q, dy_d;
  logic           valid_q, valid_d;
  logic [NW-1:0]  cnt_q, cnt_d;
  logic           err_q, err_d;
  logic           rd_en;
  logic [2*ADDRESS_WIDTH-1:0] rd_addr;

  logic [1:0]     dec_op;
  logic           dec_dx;
  logic           dec_dy;
  logic           dec_illegal;

  // Op counter holds at all-ones instead of wrapping.
  function automatic logic [NW-1:0] sat_inc(input logic [NW-1:0] v);
    return (&v) ? v : v + NW'(1);
  endfunction

  dir_decode #(
    .DIRECTION_WIDTH(DIRECTION_WIDTH)
  ) u_dir_decode (
    .word    (rd_data_i),
    .op_code (dec_op),
    .dx      (dec_dx),
    .dy      (dec_dy),
    .illegal (dec_illegal)
  );

  // Next-state, datapath updates and read strobe for the traceback walk.
  always_comb begin
    state_d = state_q;
    xi_d    = xi_q;
    yi_d    = yi_q;
    local_d = local_q;
    wcnt_d  = wcnt_q;
    code_d  = code_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    rd_en   = 1'b0;
    rd_addr = '0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          xi_d    = {1'b0, start_x_i} + CW'(1);
          yi_d    = {1'b0, start_y_i} + CW'(1);
          local_d = local_mode_i;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        if (xi_q != '0 && yi_q != '0) begin
          // xi/yi are nonzero here, so the low bits minus one equal the cell index.
          rd_en   = 1'b1;
          rd_addr = {xi_q[ADDRESS_WIDTH-1:0] - ADDRESS_WIDTH'(1),
                     yi_q[ADDRESS_WIDTH-1:0] - ADDRESS_WIDTH'(1)};
          wcnt_d  = '0;
          state_d = ST_WAIT;
        end else if ((xi_q == '0 && yi_q == '0) || local_q) begin
          state_d = ST_DONE;
        end else begin
          // One axis is exhausted: the remaining leading gap is flushed without reads.
          valid_d = 1'b1;
          code_d  = (xi_q == '0) ? OP_D : OP_I;
          state_d = ST_FLUSH;
        end
      end
      ST_WAIT: begin
        if (wcnt_q == LW'(RD_LATENCY - 1)) begin
          if (dec_illegal) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            code_d  = dec_op;
            dx_d    = dec_dx;
            dy_d    = dec_dy;
            valid_d = 1'b1;
            state_d = ST_EMIT;
          end
        end else begin
          wcnt_d = wcnt_q + LW'(1);
        end
      end
      ST_EMIT: begin
        if (op_ready_i) begin
          valid_d = 1'b0;
          xi_d    = xi_q - CW'(dx_q);
          yi_d    = yi_q - CW'(dy_q);
          cnt_d   = sat_inc(cnt_q);
          state_d = ST_READ;
        end
      end
      ST_FLUSH: begin
        if (xi_q == '0 && yi_q == '0) begin
          valid_d = 1'b0;
          state_d = ST_DONE;
        end else if (op_ready_i) begin
          cnt_d = sat_inc(cnt_q);
          if (code_q == OP_D) begin
            yi_d = yi_q - CW'(1);
          end else begin
            xi_d = xi_q - CW'(1);
          end
          if (xi_d == '0 && yi_d == '0) begin
            valid_d = 1'b0;
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any walk in progress.
  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= ST_IDLE;
      xi_q    <= '0;
      yi_q    <= '0;
      local_q <= 1'b0;
      wcnt_q  <= '0;
      code_q  <= OP_NONE;
      dx_q    <= 1'b0;
      dy_q    <= 1'b0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      xi_q    <= xi_d;
      yi_q    <= yi_d;
      local_q <= local_d;
      wcnt_q  <= wcnt_d;
      code_q  <= code_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign rd_en_o    = rd_en;
  assign rd_addr_o  = rd_addr;
  assign op_valid_o = valid_q;
  assign op_code_o  = code_q;
  assign op_count_o = cnt_q;
  assign busy_o     = (state_q != ST_IDLE);
  assign done_o     = (state_q == ST_DONE);
  assign error_o    = err_q;

endmodule

// File: tb/tb_traceback_unit.sv
// Bench for traceback_unit: directed tracebacks against a small direction
// memory model, with an op scoreboard checked by a separate monitor.
module tb_traceback_unit;
  import align_pkg::*;

  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset_i = 1'b0;
  logic          start = 1'b0;
  logic          sel = 1'b0;
  logic [AW-1:0] start_x = '0;
  logic [AW-1:0] start_y = '0;
  logic          local_mode = 1'b0;
  logic          ready = 1'b1;
  logic          stall = 1'b0;

  logic          start_a, start_b;
  logic          rd_en_a, rd_en_b;
  logic [2*AW-1:0] rd_addr_a, rd_addr_b;
  logic [4:0]    rd_data_a, rd_data_b;
  logic          op_valid_a, op_valid_b;
  logic [1:0]    op_code_a, op_code_b;
  logic [AW+1:0] op_count_a, op_count_b;
  logic          busy_a, busy_b, done_a, done_b, error_a, error_b;

  logic [4:0]    mem [0:255];
  logic [4:0]    pa, pb0, pb1, pb2;

  logic [1:0]    exp_q [$];
  int            n_cmp = 0;
  int            n_err = 0;
  int            rd_cnt = 0;
  int            done_cnt = 0;

  always #5 clk = ~clk;

  assign start_a = start && !sel;
  assign start_b = start && sel;

  traceback_unit #(.ADDRESS_WIDTH(AW), .DIRECTION_WIDTH(5), .RD_LATENCY(1)) u_dut_a (
    .clk(clk), .reset_i(reset_i), .start_i(start_a), .start_x_i(start_x), .start_y_i(start_y),
    .local_mode_i(local_mode), .rd_en_o(rd_en_a), .rd_addr_o(rd_addr_a), .rd_data_i(rd_data_a),
    .op_valid_o(op_valid_a), .op_code_o(op_code_a), .op_ready_i(ready), .op_count_o(op_count_a),
    .busy_o(busy_a), .done_o(done_a), .error_o(error_a));

  traceback_unit #(.ADDRESS_WIDTH(AW), .DIRECTION_WIDTH(5), .RD_LATENCY(3)) u_dut_b (
    .clk(clk), .reset_i(reset_i), .start_i(start_b), .start_x_i(start_x), .start_y_i(start_y),
    .local_mode_i(local_mode), .rd_en_o(rd_en_b), .rd_addr_o(rd_addr_b), .rd_data_i(rd_data_b),
    .op_valid_o(op_valid_b), .op_code_o(op_code_b), .op_ready_i(ready), .op_count_o(op_count_b),
    .busy_o(busy_b), .done_o(done_b), .error_o(error_b));

  wire          rd_en_s    = sel ? rd_en_b    : rd_en_a;
  wire          op_valid_s = sel ? op_valid_b : op_valid_a;
  wire [1:0]    op_code_s  = sel ? op_code_b  : op_code_a;
  wire [AW+1:0] op_count_s = sel ? op_count_b : op_count_a;
  wire          busy_s     = sel ? busy_b     : busy_a;
  wire          done_s     = sel ? done_b     : done_a;
  wire          error_s    = sel ? error_b    : error_a;

  // Direction memory: data appears RD_LATENCY cycles after the strobe and is
  // zero (an illegal word) otherwise, so a mistimed capture is visible.
  always @(posedge clk) begin
    pa  <= rd_en_a ? mem[rd_addr_a] : 5'b00000;
    pb0 <= rd_en_b ? mem[rd_addr_b] : 5'b00000;
    pb1 <= pb0;
    pb2 <= pb1;
  end
  assign rd_data_a = pa;
  assign rd_data_b = pb2;

  // Consumer: always ready, or in stall mode hold ready low 5 cycles per op.
  initial begin
    int wait_ctr;
    wait_ctr = 0;
    forever begin
      @(posedge clk);
      #2;
      if (!stall) begin
        ready = 1'b1;
      end else if (op_valid_s) begin
        if (wait_ctr < 5) begin
          ready = 1'b0;
          wait_ctr++;
        end else begin
          ready = 1'b1;
          wait_ctr = 0;
        end
      end else begin
        ready = 1'b0;
        wait_ctr = 0;
      end
    end
  end

  // Monitor: pops the scoreboard on each accepted op and checks handshake holds.
  initial begin
    logic       pend;
    logic [1:0] pend_code;
    logic [1:0] e;
    pend = 1'b0;
    pend_code = 2'b00;
    forever begin
      @(negedge clk);
      if (!reset_i) begin
        pend = 1'b0;
      end else begin
        if (rd_en_s) rd_cnt++;
        if (done_s) done_cnt++;
        if (pend) begin
          n_cmp++;
          if (op_valid_s !== 1'b1 || op_code_s !== pend_code) begin
            n_err++;
            $display("FAIL op_hold: valid=%0b code=%0d, required valid=1 code=%0d", op_valid_s, op_code_s, pend_code);
          end
        end
        if (op_valid_s) begin
          n_cmp++;
          if (rd_en_s !== 1'b0) begin
            n_err++;
            $display("FAIL read_while_pending: rd_en=%0b, required 0", rd_en_s);
          end
        end
        if (op_valid_s && ready) begin
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL op_unexpected: got code %0d, required no op", op_code_s);
          end else begin
            e = exp_q.pop_front();
            if (op_code_s !== e) begin
              n_err++;
              $display("FAIL op_code: got %0d, required %0d", op_code_s, e);
            end
          end
          pend = 1'b0;
        end else if (op_valid_s) begin
          pend = 1'b1;
          pend_code = op_code_s;
        end else begin
          pend = 1'b0;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask

  task automatic mem_clear();
    for (int i = 0; i < 256; i++) mem[i] = 5'b00000;
  endtask

  task automatic set_cell(input int x, input int y, input logic [4:0] w);
    mem[(x << 4) | y] = w;
  endtask

  task automatic mem_diag();
    mem_clear();
    for (int x = 0; x < 4; x++)
      for (int y = 0; y < 4; y++) set_cell(x, y, 5'b10000);
  endtask

  task automatic mem_gap(input logic hats);
    mem_clear();
    set_cell(2, 2, hats ? 5'b11111 : 5'b10000);
    set_cell(1, 1, hats ? 5'b01011 : 5'b00011);
    set_cell(0, 1, hats ? 5'b01111 : 5'b00111);
    set_cell(0, 0, 5'b10000);
  endtask

  task automatic push4(input logic [1:0] a, input logic [1:0] b, input logic [1:0] c, input logic [1:0] d);
    exp_q.push_back(a);
    exp_q.push_back(b);
    exp_q.push_back(c);
    exp_q.push_back(d);
  endtask

  task automatic run(input int sx, input int sy, input logic loc, input int cnt,
                     input logic err, input int reads, input bit poke);
    int cyc;
    @(posedge clk);
    #1;
    rd_cnt = 0;
    done_cnt = 0;
    start_x = AW'(sx);
    start_y = AW'(sy);
    local_mode = loc;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_after_start", busy_s, 1);
    chk("error_cleared", error_s, 0);
    chk("count_cleared", op_count_s, 0);
    if (poke) begin
      repeat (3) @(posedge clk);
      #1;
      start_x = AW'(1);
      start_y = AW'(0);
      local_mode = ~loc;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    cyc = 0;
    while (done_s !== 1'b1 && cyc < 3000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("done_seen", done_s, 1);
    chk("op_count", op_count_s, cnt);
    chk("error_flag", error_s, err);
    chk("ops_outstanding", exp_q.size(), 0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    chk("done_pulses", done_cnt, 1);
    chk("reads", rd_cnt, reads);
    chk("busy_idle", busy_s, 0);
  endtask

  initial begin
    int cyc;
    mem_clear();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rd_en", rd_en_a, 0);
    chk("rst_rd_addr", rd_addr_a, 0);
    chk("rst_valid", op_valid_a, 0);
    chk("rst_code", op_code_a, 0);
    chk("rst_count", op_count_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_error", error_a, 0);
    reset_i = 1'b1;

    // Full diagonal.
    mem_diag();
    push4(OP_M, OP_M, OP_M, OP_M);
    run(3, 3, 1'b0, 4, 1'b0, 4, 1'b0);

    // Gap path, plain and hat encodings.
    mem_gap(1'b0);
    push4(OP_M, OP_I, OP_D, OP_M);
    run(2, 2, 1'b0, 4, 1'b0, 4, 1'b0);
    mem_gap(1'b1);
    push4(OP_M, OP_I, OP_D, OP_M);
    run(2, 2, 1'b0, 4, 1'b0, 4, 1'b0);

    // Leading flush, global then local.
    mem_clear();
    set_cell(0, 3, 5'b00111);
    set_cell(0, 2, 5'b10000);
    push4(OP_D, OP_M, OP_D, OP_D);
    run(0, 3, 1'b0, 4, 1'b0, 2, 1'b0);
    exp_q.push_back(OP_D);
    exp_q.push_back(OP_M);
    run(0, 3, 1'b1, 2, 1'b0, 2, 1'b0);

    // Start at the origin with an insertion: one read then one flush D.
    mem_clear();
    set_cell(0, 0, 5'b00011);
    exp_q.push_back(OP_I);
    exp_q.push_back(OP_D);
    run(0, 0, 1'b0, 2, 1'b0, 1, 1'b0);

    // Backpressure on the diagonal.
    mem_diag();
    stall = 1'b1;
    push4(OP_M, OP_M, OP_M, OP_M);
    run(3, 3, 1'b0, 4, 1'b0, 4, 1'b0);
    stall = 1'b0;

    // Illegal word, then a clean run clears the flag.
    mem_clear();
    set_cell(1, 1, 5'b00001);
    run(1, 1, 1'b0, 0, 1'b1, 1, 1'b0);
    mem_gap(1'b0);
    push4(OP_M, OP_I, OP_D, OP_M);
    run(2, 2, 1'b0, 4, 1'b0, 4, 1'b0);

    // Start while busy is ignored.
    mem_diag();
    push4(OP_M, OP_M, OP_M, OP_M);
    run(3, 3, 1'b0, 4, 1'b0, 4, 1'b1);

    // Read latency 3 on the gap path.
    sel = 1'b1;
    mem_gap(1'b0);
    push4(OP_M, OP_I, OP_D, OP_M);
    run(2, 2, 1'b0, 4, 1'b0, 4, 1'b0);
    sel = 1'b0;

    // Reset while an op is held pending.
    mem_diag();
    stall = 1'b1;
    push4(OP_M, OP_M, OP_M, OP_M);
    @(posedge clk);
    #1;
    start_x = AW'(3);
    start_y = AW'(3);
    local_mode = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc = 0;
    while (op_valid_a !== 1'b1 && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("valid_before_reset", op_valid_a, 1);
    #2;
    reset_i = 1'b0;
    #1;
    chk("mid_rst_rd_en", rd_en_a, 0);
    chk("mid_rst_rd_addr", rd_addr_a, 0);
    chk("mid_rst_valid", op_valid_a, 0);
    chk("mid_rst_code", op_code_a, 0);
    chk("mid_rst_count", op_count_a, 0);
    chk("mid_rst_busy", busy_a, 0);
    chk("mid_rst_done", done_a, 0);
    chk("mid_rst_error", error_a, 0);
    done_cnt = 0;
    @(posedge clk);
    #1;
    reset_i = 1'b1;
    exp_q.delete();
    stall = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("no_done_after_reset", done_cnt, 0);
    chk("idle_after_reset", busy_a, 0);

    // Recovery after reset.
    mem_gap(1'b0);
    push4(OP_M, OP_I, OP_D, OP_M);
    run(2, 2, 1'b0, 4, 1'b0, 4, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
